// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE-array feeder slice.
// Holds the default operand width and array size, the feeder FSM state
// encoding, and a small helper for the beat counter.
package pe_array_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SIZE_DEF       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;

  // Saturating beat-counter increment: an 8-bit count of up to 255 beats
  // must never roll over to zero.
  function automatic logic [7:0] beat_inc(input logic [7:0] cnt);
    if (cnt == 8'hFF) begin
      return cnt;
    end else begin
      return cnt + 8'd1;
    end
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length delay line used for the diagonal skew of one lane.
// Total latency is DEPTH+1 clocks; DEPTH=0 is a single register stage.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears every stage
//   din  - value entering the line
//   dout - value leaving the line (output of the last register)
module skew_delay_line
  import pe_array_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [0:DEPTH];

  // Shift register; reset wipes all in-flight contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i <= DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for a SIZE x SIZE systolic PE array.
// Accepts k_len beats of (A column, B row), skews lane r by r extra cycles,
// then zero-fills for DRAIN cycles so the array can finish accumulating.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start, k_len      - job request and beat count (sampled together in IDLE)
//   in_valid/in_ready - upstream beat handshake
//   in_a, in_b        - one A column / one B row, lane-packed
//   a_edge, b_edge    - skewed operands to west / north array edges
//   a_vld, b_vld      - per-lane flag marking real (non-bubble) data
//   acc_clr           - accumulator clear, pulsed on the cycle a job starts
//   busy, done        - job in progress; one-cycle completion pulse
module systolic_feeder
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SIZE       = SIZE_DEF,
  parameter int DRAIN      = 3*SIZE-2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] in_a,
  input  logic [SIZE*DATA_WIDTH-1:0] in_b,
  output logic [SIZE*DATA_WIDTH-1:0] a_edge,
  output logic [SIZE*DATA_WIDTH-1:0] b_edge,
  output logic [SIZE-1:0]            a_vld,
  output logic [SIZE-1:0]            b_vld,
  output logic                       acc_clr,
  output logic                       busy,
  output logic                       done
);

  localparam int FW = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DRAIN - 1);

  feeder_state_t state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    klen_q, klen_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          accept;

  // A beat only enters the skew lines while streaming; everything else is zero.
  assign accept = (state_q == ST_STREAM) && in_valid;

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      klen_q  <= 8'd0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic and control outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    klen_d   = klen_q;
    flush_d  = flush_q;
    acc_clr  = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        // acc_clr is combinational on start; gate it so it stays low in reset.
        if (start && (k_len != 8'd0) && !rst) begin
          state_d = ST_STREAM;
          klen_d  = k_len;
          cnt_d   = 8'd0;
          acc_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = beat_inc(cnt_q);
          if (beat_inc(cnt_q) == klen_q) begin
            state_d = ST_FLUSH;
            flush_d = '0;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = ST_DONE;
        end else begin
          flush_d = flush_q + {{(FW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // One delay line per lane per edge; the valid flag rides as the top bit.
  for (genvar r = 0; r < SIZE; r++) begin : g_lane
    logic [DATA_WIDTH:0] a_din, a_dout, b_din, b_dout;

    assign a_din = accept ? {1'b1, in_a[r*DATA_WIDTH +: DATA_WIDTH]} : '0;
    assign b_din = accept ? {1'b1, in_b[r*DATA_WIDTH +: DATA_WIDTH]} : '0;

    skew_delay_line #(.WIDTH(DATA_WIDTH + 1), .DEPTH(r)) u_a_line (
      .clk  (clk),
      .rst  (rst),
      .din  (a_din),
      .dout (a_dout)
    );

    skew_delay_line #(.WIDTH(DATA_WIDTH + 1), .DEPTH(r)) u_b_line (
      .clk  (clk),
      .rst  (rst),
      .din  (b_din),
      .dout (b_dout)
    );

    assign a_edge[r*DATA_WIDTH +: DATA_WIDTH] = a_dout[DATA_WIDTH-1:0];
    assign b_edge[r*DATA_WIDTH +: DATA_WIDTH] = b_dout[DATA_WIDTH-1:0];
    assign a_vld[r] = a_dout[DATA_WIDTH];
    assign b_vld[r] = b_dout[DATA_WIDTH];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder.
// A job-level model (beats accepted per cycle, lane r sees cycle n-1-r) is
// compared against the DUT every cycle; directed scenarios add literal checks.
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int SZ = 4;
  localparam int DR = 3*SZ-2;
  localparam int LW = SZ*DW;
  localparam int NH = 1024;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready;
  logic [7:0]    k_len;
  logic [LW-1:0] in_a, in_b, a_edge, b_edge;
  logic [SZ-1:0] a_vld, b_vld;
  logic          acc_clr, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  systolic_feeder #(.DATA_WIDTH(DW), .SIZE(SZ), .DRAIN(DR)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .a_edge(a_edge), .b_edge(b_edge), .a_vld(a_vld), .b_vld(b_vld),
    .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] pack(input int base);
    logic [LW-1:0] v;
    for (int r = 0; r < SZ; r++) v[r*DW +: DW] = DW'(base + r);
    return v;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [LW-1:0] h_a [NH];
  logic [LW-1:0] h_b [NH];
  logic          h_v [NH];
  logic          m_active = 1'b0;
  int            m_k = 0, m_got = 0, m_done = -1;

  always @(negedge clk) begin : cmp
    logic [LW-1:0] ea, eb;
    logic [SZ-1:0] ev;
    logic          e_rdy, e_busy, e_done, e_clr;
    int            n, idx;
    n  = cyc;
    ea = '0; eb = '0; ev = '0;
    if (!rst) begin
      for (int r = 0; r < SZ; r++) begin
        idx = n - 1 - r;
        if (idx >= 0) begin
          ea[r*DW +: DW] = h_a[idx % NH][r*DW +: DW];
          eb[r*DW +: DW] = h_b[idx % NH][r*DW +: DW];
          ev[r]          = h_v[idx % NH];
        end
      end
    end
    e_rdy  = !rst && m_active && (m_got < m_k);
    e_busy = !rst && m_active;
    e_done = !rst && m_active && (n == m_done);
    e_clr  = !rst && !m_active && start && (k_len != 8'd0);
    check("a_edge", a_edge, ea);
    check("b_edge", b_edge, eb);
    check("a_vld", LW'(a_vld), LW'(ev));
    check("b_vld", LW'(b_vld), LW'(ev));
    check("in_ready", LW'(in_ready), LW'(e_rdy));
    check("busy", LW'(busy), LW'(e_busy));
    check("done", LW'(done), LW'(e_done));
    check("acc_clr", LW'(acc_clr), LW'(e_clr));
    // advance model past the coming edge
    h_a[n % NH] = '0; h_b[n % NH] = '0; h_v[n % NH] = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_done = -1;
      for (int i = 0; i < NH; i++) begin
        h_a[i] = '0; h_b[i] = '0; h_v[i] = 1'b0;
      end
    end else if (e_clr) begin
      m_active = 1'b1; m_k = int'(k_len); m_got = 0; m_done = -1;
    end else if (m_active) begin
      if (e_done) m_active = 1'b0;
      if (e_rdy && in_valid) begin
        h_a[n % NH] = in_a; h_b[n % NH] = in_b; h_v[n % NH] = 1'b1;
        m_got++;
        if (m_got == m_k) m_done = n + DR + 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, required a pulse", bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, at, rdy_cnt, done_cnt;
    rst = 1'b1; start = 1'b0; k_len = 8'd0; in_valid = 1'b0; in_a = '0; in_b = '0;
    @(negedge clk);
    check("rst_busy", LW'(busy), LW'(1'b0));
    check("rst_ready", LW'(in_ready), LW'(1'b0));
    check("rst_a_edge", a_edge, '0);
    repeat (2) tick();
    rst = 1'b0;

    // Basic job, k_len=3, A lanes 1..4
    tick();
    start = 1'b1; k_len = 8'd3; in_valid = 1'b1; in_a = pack(1); in_b = pack(101); s = cyc;
    @(negedge clk);
    check("acc_clr_on_start", LW'(acc_clr), LW'(1'b1));
    tick(); start = 1'b0;
    tick(); in_a = pack(5); in_b = pack(105);
    tick(); in_a = pack(9); in_b = pack(109);
    tick(); in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("a_lane3_latency", LW'(a_edge[3*DW +: DW]), LW'(32'd4));
    check("b_lane3_latency", LW'(b_edge[3*DW +: DW]), LW'(32'd104));
    while (cyc < s + 3 + DR + 1) tick();
    start = 1'b1; k_len = 8'd2;
    @(negedge clk);
    check("done_at_3_plus_drain_plus_1", LW'(done), LW'(1'b1));
    check("start_on_done_ignored", LW'(acc_clr), LW'(1'b0));
    tick(); start = 1'b0;
    @(negedge clk);
    check("idle_after_done", LW'(busy), LW'(1'b0));

    // k_len=2 with a bubble between beats
    tick();
    start = 1'b1; k_len = 8'd2; in_valid = 1'b0; s = cyc;
    tick(); start = 1'b0; in_valid = 1'b1; in_a = pack(17); in_b = pack(117);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_bubble", LW'(in_ready), LW'(1'b1));
    tick(); in_valid = 1'b1; in_a = pack(21); in_b = pack(121);
    @(negedge clk);
    check("bubble_vld", LW'(a_vld), LW'(4'b0010));
    check("bubble_lane0_zero", LW'(a_edge[DW-1:0]), LW'(32'd0));
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("ready_low_after_2", LW'(in_ready), LW'(1'b0));
    tick();
    wait_done(40, at);
    check("bubble_job_done_cycle", LW'(at - s), LW'(14));

    // k_len=0 ignored; start while busy ignored
    tick();
    start = 1'b1; k_len = 8'd0;
    @(negedge clk);
    check("klen0_no_clr", LW'(acc_clr), LW'(1'b0));
    tick(); start = 1'b0;
    @(negedge clk);
    check("klen0_not_busy", LW'(busy), LW'(1'b0));
    tick();
    start = 1'b1; k_len = 8'd2; in_valid = 1'b1; in_a = pack(31); in_b = pack(131); s = cyc;
    tick(); k_len = 8'd5; in_a = pack(35); in_b = pack(135);
    @(negedge clk);
    check("busy_start_no_clr", LW'(acc_clr), LW'(1'b0));
    tick(); start = 1'b0; in_a = pack(39); in_b = pack(139);
    tick(); in_valid = 1'b0;
    wait_done(40, at);
    check("busy_start_done_cycle", LW'(at - s), LW'(13));

    // reset during FLUSH
    tick();
    start = 1'b1; k_len = 8'd3; in_valid = 1'b1; in_a = pack(41); in_b = pack(141); s = cyc;
    tick(); start = 1'b0;
    tick(); in_a = pack(45);
    tick(); in_a = pack(49);
    tick(); in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("pre_rst_lane1_live", LW'(a_vld[1]), LW'(1'b1));
    tick(); rst = 1'b1;
    @(negedge clk);
    check("rst_flush_a_edge", a_edge, '0);
    check("rst_flush_b_vld", LW'(b_vld), '0);
    check("rst_flush_busy", LW'(busy), LW'(1'b0));
    tick(); tick(); rst = 1'b0;
    tick();
    start = 1'b1; k_len = 8'd1; in_valid = 1'b1; in_a = pack(61); in_b = pack(161); s = cyc;
    tick(); start = 1'b0;
    tick(); in_valid = 1'b0;
    wait_done(40, at);
    check("post_rst_job_done_cycle", LW'(at - s), LW'(12));

    // k_len=255 continuous stream; in_valid stays high throughout
    tick();
    start = 1'b1; k_len = 8'd255; in_valid = 1'b1; s = cyc;
    rdy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      in_a = pack(1000 + 4*i); in_b = pack(5000 + 4*i);
      @(negedge clk);
      if (in_ready) rdy_cnt++;
      if (done) done_cnt++;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    check("k255_beats", LW'(rdy_cnt), LW'(255));
    check("k255_done_pulses", LW'(done_cnt), LW'(1));

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
